booth_encoder_seq: RTL

- Sequential radix-4 Booth encoder for the multiplier operand. It is the producer side of the Booth partial-product path.
- Accepts one WIDTH-bit multiplier x per transaction over a valid/ready handshake.
- Emits its WIDTH/2 Booth action codes one per cycle, least-significant digit first, over a second valid/ready handshake.
- Each action code is the 3-bit Booth triplet that the Shifter/BoothDecoder partial-product generators consume directly.

---
 rtl/booth_encoder_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/booth_encoder_seq.sv
// ============================================================================
// Module   : booth_encoder_seq
// Brief    : Sequential radix-4 Booth encoder. It emits one Booth triplet per
//            cycle over a valid/ready stream. The optional macro
//            BOOTH_ZERO_SKIP_EN skips zero digits except the final one.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_encoder_seq #(
  parameter int WIDTH = 8,
  localparam int NDIGITS = WIDTH / 2,
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       action,
  output logic [IDXW-1:0]  index,
  output logic             last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NDIGITS - 1);

  state_t          r_state;
  logic [WIDTH:0]  r_op;
  logic [IDXW-1:0] r_index;
  logic [2:0]      r_action;
  logic            r_last;
  logic            r_valid;

  logic [WIDTH:0]  w_op_in;
  logic [IDXW-1:0] w_first;
  logic [IDXW-1:0] w_next;

  // Bit 0 of the operand register is the implicit x[-1] = 0.
  assign w_op_in = {x, 1'b0};

  function automatic logic [2:0] triplet(input logic [WIDTH:0] op,
                                         input logic [IDXW-1:0] idx);
    return op[{idx, 1'b0} +: 3];
  endfunction

`ifdef BOOTH_ZERO_SKIP_EN
  logic [IDXW:0] w_next_start;

  // Lowest non-zero digit at or above start, falling back to the final digit.
  function automatic logic [IDXW-1:0] pick_digit(input logic [WIDTH:0] op,
                                                 input logic [IDXW:0]  start);
    logic [IDXW-1:0] sel;
    logic [2:0]      a;
    sel = c_last_idx;
    for (int j = NDIGITS - 2; j >= 0; j--) begin
      a = op[2*j +: 3];
      if (((IDXW+1)'(j) >= start) && (a != 3'b000) && (a != 3'b111)) begin
        sel = IDXW'(j);
      end
    end
    return sel;
  endfunction

  assign w_next_start = {1'b0, r_index} + (IDXW+1)'(1);

  always_comb begin
    w_first = pick_digit(w_op_in, '0);
    w_next  = pick_digit(r_op, w_next_start);
  end
`else
  always_comb begin
    w_first = '0;
    w_next  = r_index + IDXW'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_index  <= '0;
      r_action <= 3'b000;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op     <= w_op_in;
            r_index  <= w_first;
            r_action <= triplet(w_op_in, w_first);
            r_last   <= (w_first == c_last_idx);
            r_valid  <= 1'b1;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_index  <= w_next;
              r_action <= triplet(r_op, w_next);
              r_last   <= (w_next == c_last_idx);
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign action    = r_action;
  assign index     = r_index;
  assign last      = r_last;

endmodule

`default_nettype wire
